// File: rtl/adder_share_arbiter_if.sv
// Handshake bundle between the two requesters and the shared adder arbiter.
interface adder_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       req_valid;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic [1:0]       req_grant;
    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_carry;
    logic             rsp_ovf;
    logic             rsp_ready;

    // Requester / result-consumer side
    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        input  req_grant, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_ovf
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        output req_grant, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_ovf
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit adder between two
// requesters. One operation in flight at a time: IDLE grants, EXEC adds,
// DONE holds the result until the owner acknowledges it.
module adder_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    adder_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state_reg;
    logic             prio_reg;
    logic             owner_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             rsp_valid_reg;
    logic             rsp_id_reg;
    logic [WIDTH-1:0] rsp_sum_reg;
    logic             rsp_carry_reg;
    logic             rsp_ovf_reg;

    logic             grant_en;
    logic             grant_id;
    logic [1:0]       grant_vec;
    logic [WIDTH:0]   sum_wide;

    // Pick the winner: a lone requester always wins, a tie goes to prio.
    // Reset suppresses the grant so no operands are accepted while aborting.
    always_comb begin
        grant_en = (state_reg == IDLE) && !Reset && (bus.req_valid != 2'b00);
        grant_id = (bus.req_valid == 2'b11) ? prio_reg : bus.req_valid[1];
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant_vec[gi] = grant_en && (grant_id == (gi == 1));
        end
    endgenerate

    // Extra top bit captures the carry out of the MSB.
    assign sum_wide = {1'b0, a_reg} + {1'b0, b_reg};

    assign bus.req_grant = grant_vec;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_sum   = rsp_sum_reg;
    assign bus.rsp_carry = rsp_carry_reg;
    assign bus.rsp_ovf   = rsp_ovf_reg;

    // Control FSM plus operand latch and registered result stage.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= IDLE;
            prio_reg      <= 1'b0;
            owner_reg     <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_sum_reg   <= '0;
            rsp_carry_reg <= 1'b0;
            rsp_ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_en) begin
                        owner_reg <= grant_id;
                        a_reg     <= grant_id ? bus.req_a1 : bus.req_a0;
                        b_reg     <= grant_id ? bus.req_b1 : bus.req_b0;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum_reg   <= sum_wide[WIDTH-1:0];
                    rsp_carry_reg <= sum_wide[WIDTH];
                    // Overflow: operands agree in sign but the result does not.
                    rsp_ovf_reg   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                     (sum_wide[WIDTH-1] != a_reg[WIDTH-1]);
                    rsp_valid_reg <= 1'b1;
                    rsp_id_reg    <= owner_reg;
                    state_reg     <= DONE;
                end
                DONE: begin
                    // Result stays put until consumed; then the other side is favoured.
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        prio_reg      <= ~owner_reg;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed corner cases followed
// by random transactions, all compared against a behavioural model.
module tb_adder_share_arbiter;
    logic Clk = 1'b0;
    logic Reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic model_prio;

    adder_share_arbiter_if #(.WIDTH(32)) bus ();

    adder_share_arbiter #(.WIDTH(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        bus.req_valid = 2'($urandom);
        bus.req_a0    = $urandom;
        bus.req_b0    = $urandom;
        bus.req_a1    = $urandom;
        bus.req_b1    = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, 64'(bus.req_grant), 64'd0);
        check({tag, "_valid"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, "_id"},    64'(bus.rsp_id),    64'd0);
        check({tag, "_sum"},   64'(bus.rsp_sum),   64'd0);
        check({tag, "_carry"}, 64'(bus.rsp_carry), 64'd0);
        check({tag, "_ovf"},   64'(bus.rsp_ovf),   64'd0);
    endtask

    // One complete transaction: present request in IDLE, verify grant,
    // latency, result, hold-under-backpressure, and release.
    task automatic txn(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1, input int hold,
                       input bit do_release);
        logic        exp_id;
        logic [31:0] ea, eb, esum;
        logic [32:0] wide;
        logic        ecarry, eovf;
        longint      s;
        exp_id = (v == 2'b11) ? model_prio : v[1];
        ea     = exp_id ? a1 : a0;
        eb     = exp_id ? b1 : b0;
        wide   = {1'b0, ea} + {1'b0, eb};
        esum   = wide[31:0];
        ecarry = wide[32];
        s      = longint'($signed(ea)) + longint'($signed(eb));
        eovf   = (s != longint'($signed(esum)));

        @(negedge Clk);
        bus.req_valid = v;
        bus.req_a0 = a0; bus.req_b0 = b0; bus.req_a1 = a1; bus.req_b1 = b1;
        bus.rsp_ready = 1'b0;
        #1;
        check("grant", 64'(bus.req_grant), exp_id ? 64'd2 : 64'd1);
        $display("txn valid=%b a0=%h b0=%h a1=%h b1=%h -> expect id=%0d sum=%h c=%0d v=%0d",
                 v, a0, b0, a1, b1, exp_id, esum, ecarry, eovf);

        @(negedge Clk);
        scramble();
        bus.rsp_ready = 1'($urandom);
        #1;
        check("exec_valid", 64'(bus.rsp_valid), 64'd0);
        check("exec_grant", 64'(bus.req_grant), 64'd0);

        @(negedge Clk);
        bus.rsp_ready = 1'b0;
        #1;
        check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("rsp_id",    64'(bus.rsp_id),    64'(exp_id));
        check("rsp_sum",   64'(bus.rsp_sum),   64'(esum));
        check("rsp_carry", 64'(bus.rsp_carry), 64'(ecarry));
        check("rsp_ovf",   64'(bus.rsp_ovf),   64'(eovf));

        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            scramble();
            #1;
            check("hold_valid", 64'(bus.rsp_valid), 64'd1);
            check("hold_sum",   64'(bus.rsp_sum),   64'(esum));
            check("hold_id",    64'(bus.rsp_id),    64'(exp_id));
            check("hold_grant", 64'(bus.req_grant), 64'd0);
        end

        if (do_release) begin
            bus.req_valid = 2'b00;
            bus.rsp_ready = 1'b1;
            @(negedge Clk);
            bus.rsp_ready = 1'b0;
            #1;
            check("release_valid", 64'(bus.rsp_valid), 64'd0);
            check("release_grant", 64'(bus.req_grant), 64'd0);
            model_prio = ~exp_id;
        end
    endtask

    initial begin
        model_prio    = 1'b0;
        Reset         = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_a0 = '0; bus.req_b0 = '0; bus.req_a1 = '0; bus.req_b1 = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge Clk);
        #1;
        check_reset_outputs("reset");
        @(negedge Clk);
        Reset = 1'b0;
        bus.req_valid = 2'b00;

        // Single requester 0
        txn(2'b01, 32'd5, 32'd7, 32'd0, 32'd0, 0, 1'b1);
        // Tie alternates 1,0,1,0 ... after requester 0 just completed
        for (int k = 0; k < 4; k++)
            txn(2'b11, 32'd1, 32'd1, 32'd2, 32'd2, 0, 1'b1);
        // Wrap and signed overflow
        txn(2'b01, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 0, 1'b1);
        txn(2'b10, 32'd0, 32'd0, 32'h7FFFFFFF, 32'd1, 0, 1'b1);
        // Backpressure for five cycles
        txn(2'b11, $urandom, $urandom, $urandom, $urandom, 5, 1'b1);

        // Request withdrawn before any grant could matter: nothing issued
        @(negedge Clk);
        bus.req_valid = 2'b00;
        repeat (3) begin
            @(negedge Clk);
            #1;
            check("idle_grant", 64'(bus.req_grant), 64'd0);
            check("idle_valid", 64'(bus.rsp_valid), 64'd0);
        end

        // Reset while a result is pending in DONE
        txn(2'b10, 32'd0, 32'd0, 32'd9, 32'd9, 2, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        check("rst_in_done_grant", 64'(bus.req_grant), 64'd0);
        @(negedge Clk);
        #1;
        check_reset_outputs("rst_done");
        Reset = 1'b0;
        bus.req_valid = 2'b00;
        model_prio = 1'b0;
        txn(2'b11, 32'd3, 32'd4, 32'd5, 32'd6, 0, 1'b1);

        // Random traffic
        for (int k = 0; k < 40; k++) begin
            logic [1:0] v;
            v = 2'($urandom_range(1, 3));
            txn(v, $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 3), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
